// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the oversampling UART receiver.
//   rx_state_e       - receiver FSM states
//   parity_type_e    - parity sense selected by parity_type_i
//   uart_rx_status_t - one-cycle status pulses driven on the commit cycle
//   MIN_DATA_BITS    - smallest frame data width; data_bits_i is clamped to it
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_state_e;

    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parity_type_e;

    typedef struct packed {
        logic parity_error;
        logic frame_error;
        logic overrun;
        logic brk;
    } uart_rx_status_t;

    localparam int MIN_DATA_BITS = 5;

endpackage

// File: rtl/uart_rx_os_baud_tick.sv
// uart_baud_tick: oversample clock-enable generator shared by the UART RX/TX.
//   clk, arst_n  - clock, asynchronous active-low reset
//   clear        - synchronous restart: counter and sample index go to 0
//   div          - clk cycles per tick (0 behaves as 1)
//   tick         - high on the terminal count of the divisor counter
//   sample_idx   - index of the current tick within the bit, 0..OVERSAMPLE-1
module uart_baud_tick #(
    parameter int DIV_WIDTH  = 32,
    parameter int OVERSAMPLE = 16
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          clear,
    input  logic [DIV_WIDTH-1:0]          div,
    output logic                          tick,
    output logic [$clog2(OVERSAMPLE)-1:0] sample_idx
);

    localparam int IDX_W = $clog2(OVERSAMPLE);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]     IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(OVERSAMPLE - 1);

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_eff;

    assign div_eff = (div == '0) ? DIV_ONE : div;

    // The divisor is only sampled at a wrap or a clear, so a change in div
    // never strands the counter above a smaller terminal count.
    assign tick = (cnt == div_q - DIV_ONE);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt        <= '0;
            div_q      <= DIV_ONE;
            sample_idx <= '0;
        end else if (clear) begin
            cnt        <= '0;
            div_q      <= div_eff;
            sample_idx <= '0;
        end else if (tick) begin
            cnt        <= '0;
            div_q      <= div_eff;
            sample_idx <= (sample_idx == IDX_LAST) ? '0 : sample_idx + IDX_ONE;
        end else begin
            cnt <= cnt + DIV_ONE;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: single-clock oversampling UART receiver.
//   clk_i, arst_ni     - system clock, asynchronous active-low reset
//   div_i              - clk_i cycles per oversample tick
//   data_bits_i        - data bits per frame (clamped to 5..MAX_DATA_BITS)
//   parity_en_i        - parity bit present; parity_type_i 0 even / 1 odd
//   extra_stop_i       - two stop bits
//   rx_i               - asynchronous serial input
//   data_o/data_valid_o/data_ready_i - single-entry received word buffer
//   parity_error_o, frame_error_o, overrun_o, break_o - one-cycle pulses
module uart_rx_os
    import uart_rx_pkg::*;
#(
    parameter int MAX_DATA_BITS = 8,
    parameter int OVERSAMPLE    = 16,
    parameter int DIV_WIDTH     = 32,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                               clk_i,
    input  logic                               arst_ni,
    input  logic [DIV_WIDTH-1:0]               div_i,
    input  logic [$clog2(MAX_DATA_BITS+1)-1:0] data_bits_i,
    input  logic                               parity_en_i,
    input  logic                               parity_type_i,
    input  logic                               extra_stop_i,
    input  logic                               rx_i,
    output logic [MAX_DATA_BITS-1:0]           data_o,
    output logic                               data_valid_o,
    input  logic                               data_ready_i,
    output logic                               parity_error_o,
    output logic                               frame_error_o,
    output logic                               overrun_o,
    output logic                               break_o
);

    localparam int CNT_W = $clog2(MAX_DATA_BITS + 1);
    localparam int IDX_W = $clog2(OVERSAMPLE);
    localparam logic [IDX_W-1:0] IDX_S0  = IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_S1  = IDX_W'(OVERSAMPLE / 2);
    localparam logic [IDX_W-1:0] IDX_S2  = IDX_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] NB_MIN  = CNT_W'(MIN_DATA_BITS);
    localparam logic [CNT_W-1:0] NB_MAX  = CNT_W'(MAX_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   fall;

    rx_state_e              state;
    logic                   tick;
    logic [IDX_W-1:0]       sample_idx;
    logic                   start_det;
    logic                   samp_a;
    logic                   samp_b;
    logic                   decide;
    logic                   bit_val;

    logic [CNT_W-1:0]         nb_clamped;
    logic [CNT_W-1:0]         nbits_q;
    logic [CNT_W-1:0]         bit_cnt;
    logic                     par_en_q;
    parity_type_e             par_type_q;
    logic                     two_stop_q;
    logic [MAX_DATA_BITS-1:0] shift_q;
    logic                     par_bit_q;
    logic                     par_err_q;
    logic                     stop1_q;

    logic                     commit;
    logic                     stop1_val;
    logic                     frame_bad;
    logic                     brk_det;

    logic [MAX_DATA_BITS-1:0] data_q;
    logic                     data_valid_q;
    uart_rx_status_t          status_q;

    // rx_i is asynchronous; it only reaches the FSM through this chain.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rx_prev <= rx_s;
        end
    end

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign fall      = rx_prev & ~rx_s;
    assign start_det = (state == IDLE) & fall;

    uart_baud_tick #(
        .DIV_WIDTH  (DIV_WIDTH),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk        (clk_i),
        .arst_n     (arst_ni),
        .clear      (start_det),
        .div        (div_i),
        .tick       (tick),
        .sample_idx (sample_idx)
    );

    always_comb begin
        nb_clamped = data_bits_i;
        if (data_bits_i < NB_MIN) begin
            nb_clamped = NB_MIN;
        end else if (data_bits_i > NB_MAX) begin
            nb_clamped = NB_MAX;
        end
    end

    // The third sample is taken live on the decision tick.
    assign decide  = tick & (sample_idx == IDX_S2);
    assign bit_val = majority3(samp_a, samp_b, rx_s);

    always_comb begin
        commit    = decide & (((state == STOP1) & ~two_stop_q) | (state == STOP2));
        stop1_val = (state == STOP2) ? stop1_q : bit_val;
        frame_bad = ~bit_val | ~stop1_val;
        brk_det   = (shift_q == '0) & ~(par_en_q & par_bit_q) & ~stop1_val;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state        <= IDLE;
            samp_a       <= 1'b1;
            samp_b       <= 1'b1;
            nbits_q      <= NB_MIN;
            bit_cnt      <= '0;
            par_en_q     <= 1'b0;
            par_type_q   <= PARITY_EVEN;
            two_stop_q   <= 1'b0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            par_err_q    <= 1'b0;
            stop1_q      <= 1'b1;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            status_q     <= '0;
        end else begin
            status_q <= '0;
            if (data_valid_q && data_ready_i) begin
                data_valid_q <= 1'b0;
            end
            if (tick && sample_idx == IDX_S0) begin
                samp_a <= rx_s;
            end
            if (tick && sample_idx == IDX_S1) begin
                samp_b <= rx_s;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state      <= START;
                        nbits_q    <= nb_clamped;
                        par_en_q   <= parity_en_i;
                        par_type_q <= parity_type_e'(parity_type_i);
                        two_stop_q <= extra_stop_i;
                        shift_q    <= '0;
                        bit_cnt    <= '0;
                        par_bit_q  <= 1'b0;
                        par_err_q  <= 1'b0;
                        stop1_q    <= 1'b1;
                    end
                end
                START: begin
                    if (decide) begin
                        state <= bit_val ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (decide) begin
                        for (int i = 0; i < MAX_DATA_BITS; i++) begin
                            if (bit_cnt == CNT_W'(i)) begin
                                shift_q[i] <= bit_val;
                            end
                        end
                        if (bit_cnt == nbits_q - CNT_ONE) begin
                            state <= par_en_q ? PARITY : STOP1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_ONE;
                        end
                    end
                end
                PARITY: begin
                    if (decide) begin
                        par_bit_q <= bit_val;
                        par_err_q <= ((^shift_q) ^ bit_val) != (par_type_q == PARITY_ODD);
                        state     <= STOP1;
                    end
                end
                STOP1: begin
                    if (decide) begin
                        if (two_stop_q) begin
                            stop1_q <= bit_val;
                            state   <= STOP2;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                STOP2: begin
                    if (decide) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Returning to IDLE at the last stop decision lets a back-to-back
            // start edge be caught; the word and flags land one cycle later.
            if (commit) begin
                status_q.parity_error <= par_en_q & par_err_q;
                status_q.frame_error  <= frame_bad | brk_det;
                status_q.brk          <= brk_det;
                if (!data_valid_q || data_ready_i) begin
                    data_q       <= shift_q;
                    data_valid_q <= 1'b1;
                end else begin
                    status_q.overrun <= 1'b1;
                end
            end
        end
    end

    assign data_o         = data_q;
    assign data_valid_o   = data_valid_q;
    assign parity_error_o = status_q.parity_error;
    assign frame_error_o  = status_q.frame_error;
    assign overrun_o      = status_q.overrun;
    assign break_o        = status_q.brk;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: self-checking bench for uart_rx_os (table vectors,
// hand-written corner sequences and randomized frames against a model).
module tb_uart_rx_os;

    logic        clk = 1'b0;
    logic        arst_ni;
    logic [31:0] div_i;
    logic [3:0]  data_bits_i;
    logic        parity_en_i;
    logic        parity_type_i;
    logic        extra_stop_i;
    logic        rx_i;
    logic [7:0]  data_o;
    logic        data_valid_o;
    logic        data_ready_i;
    logic        parity_error_o;
    logic        frame_error_o;
    logic        overrun_o;
    logic        break_o;

    uart_rx_os #(
        .MAX_DATA_BITS (8),
        .OVERSAMPLE    (16),
        .DIV_WIDTH     (32),
        .SYNC_STAGES   (2)
    ) dut (
        .clk_i          (clk),
        .arst_ni        (arst_ni),
        .div_i          (div_i),
        .data_bits_i    (data_bits_i),
        .parity_en_i    (parity_en_i),
        .parity_type_i  (parity_type_i),
        .extra_stop_i   (extra_stop_i),
        .rx_i           (rx_i),
        .data_o         (data_o),
        .data_valid_o   (data_valid_o),
        .data_ready_i   (data_ready_i),
        .parity_error_o (parity_error_o),
        .frame_error_o  (frame_error_o),
        .overrun_o      (overrun_o),
        .break_o        (break_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         cfg_bits;
        bit         pen;
        bit         ptype;
        bit         pbit;
        bit         xs;
        bit         s1;
        bit         s2;
        int         dv;
        logic [7:0] exp_data;
        bit         exp_pe;
        bit         exp_fe;
        bit         exp_brk;
    } vec_t;

    vec_t tbl[11];

    int n_checks = 0;
    int n_pass   = 0;

    // Event monitor, sampling on the falling edge.
    int         cyc = 0;
    int         n_acc = 0, n_pe = 0, n_fe = 0, n_ov = 0, n_brk = 0, n_vhi = 0;
    int         rise_cyc = 0;
    logic [7:0] acc_data = '0;
    bit         v_prev = 1'b0;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        v_prev <= data_valid_o;
        if (data_valid_o && data_ready_i) begin
            n_acc    <= n_acc + 1;
            acc_data <= data_o;
        end
        if (data_valid_o)            n_vhi <= n_vhi + 1;
        if (data_valid_o && !v_prev) rise_cyc <= cyc;
        if (parity_error_o)          n_pe  <= n_pe + 1;
        if (frame_error_o)           n_fe  <= n_fe + 1;
        if (overrun_o)               n_ov  <= n_ov + 1;
        if (break_o)                 n_brk <= n_brk + 1;
    end

    int s_acc, s_pe, s_fe, s_ov, s_brk, s_vhi;
    int frame_start_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        s_acc = n_acc; s_pe = n_pe; s_fe = n_fe;
        s_ov  = n_ov;  s_brk = n_brk; s_vhi = n_vhi;
    endtask

    task automatic set_cfg(input int cb, input bit pen, input bit ptype, input bit xs, input int dv);
        data_bits_i   = 4'(cb);
        parity_en_i   = pen;
        parity_type_i = ptype;
        extra_stop_i  = xs;
        div_i         = 32'(dv);
        wait_cyc(2);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit pbit,
                              input bit xs, input bit s1, input bit s2, input int dv);
        int bp;
        bp = 16 * dv;
        frame_start_cyc = cyc;
        rx_i = 1'b0;
        wait_cyc(bp);
        for (int i = 0; i < nb; i++) begin
            rx_i = d[i];
            wait_cyc(bp);
        end
        if (pen) begin
            rx_i = pbit;
            wait_cyc(bp);
        end
        rx_i = s1;
        wait_cyc(bp);
        if (xs) begin
            rx_i = s2;
            wait_cyc(bp);
        end
        rx_i = 1'b1;
    endtask

    task automatic expect_frame(input string name, input logic [7:0] ed,
                                input bit epe, input bit efe, input bit ebrk);
        check({name, ".count"}, 32'(n_acc - s_acc), 32'd1);
        check({name, ".data"},  32'(acc_data), 32'(ed));
        check({name, ".perr"},  32'(n_pe - s_pe), 32'(epe));
        check({name, ".ferr"},  32'(n_fe - s_fe), 32'(efe));
        check({name, ".brk"},   32'(n_brk - s_brk), 32'(ebrk));
        check({name, ".ovr"},   32'(n_ov - s_ov), 32'd0);
        check({name, ".vlen"},  32'(n_vhi - s_vhi), 32'd1);
    endtask

    function automatic int clampnb(input int v);
        if (v < 5) return 5;
        if (v > 8) return 8;
        return v;
    endfunction

    function automatic vec_t mk(input logic [7:0] d, input int cb, input bit pen, input bit ptype,
                                input bit pbit, input bit xs, input bit s1, input bit s2, input int dv,
                                input logic [7:0] ed, input bit epe, input bit efe, input bit ebrk);
        vec_t v;
        v.data = d; v.cfg_bits = cb; v.pen = pen; v.ptype = ptype; v.pbit = pbit;
        v.xs = xs; v.s1 = s1; v.s2 = s2; v.dv = dv;
        v.exp_data = ed; v.exp_pe = epe; v.exp_fe = efe; v.exp_brk = ebrk;
        return v;
    endfunction

    initial begin
        logic [7:0] d, masked;
        int         cb, nb, dv;
        bit         pen, ptype, pbit, xs, s1, s2, epe, efe, ebrk;

        //           data  cfg pen pty pbit xs  s1  s2  div exp   pe  fe  brk
        tbl[0]  = mk(8'hA5, 8, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 4, 8'hA5, 1'b0,1'b0,1'b0);
        tbl[1]  = mk(8'h3C, 7, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b1, 4, 8'h3C, 1'b0,1'b0,1'b0);
        tbl[2]  = mk(8'h3C, 7, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b1, 4, 8'h3C, 1'b1,1'b0,1'b0);
        tbl[3]  = mk(8'h15, 5, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 4, 8'h15, 1'b0,1'b1,1'b0);
        tbl[4]  = mk(8'h55, 8, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 2, 8'h55, 1'b0,1'b0,1'b0);
        tbl[5]  = mk(8'h00, 8, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 2, 8'h00, 1'b0,1'b0,1'b0);
        tbl[6]  = mk(8'h7F, 8, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 3, 8'h7F, 1'b0,1'b1,1'b0);
        tbl[7]  = mk(8'h00, 6, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 3, 8'h00, 1'b0,1'b1,1'b1);
        tbl[8]  = mk(8'hC3, 8, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b1, 1, 8'hC3, 1'b1,1'b0,1'b0);
        tbl[9]  = mk(8'hEB, 2, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 2, 8'h0B, 1'b0,1'b0,1'b0);
        tbl[10] = mk(8'hE7,15, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 1, 8'hE7, 1'b0,1'b0,1'b0);

        arst_ni = 1'b0; rx_i = 1'b1; data_ready_i = 1'b1;
        div_i = 32'd4; data_bits_i = 4'd8; parity_en_i = 1'b0;
        parity_type_i = 1'b0; extra_stop_i = 1'b0;
        wait_cyc(3);
        check("rst.data",  32'(data_o), 32'd0);
        check("rst.valid", 32'(data_valid_o), 32'd0);
        check("rst.perr",  32'(parity_error_o), 32'd0);
        check("rst.ferr",  32'(frame_error_o), 32'd0);
        check("rst.ovr",   32'(overrun_o), 32'd0);
        check("rst.brk",   32'(break_o), 32'd0);
        arst_ni = 1'b1;
        wait_cyc(4);

        // Table vectors
        for (int k = 0; k < 11; k++) begin
            set_cfg(tbl[k].cfg_bits, tbl[k].pen, tbl[k].ptype, tbl[k].xs, tbl[k].dv);
            snap();
            send_frame(tbl[k].data, clampnb(tbl[k].cfg_bits), tbl[k].pen, tbl[k].pbit,
                       tbl[k].xs, tbl[k].s1, tbl[k].s2, tbl[k].dv);
            wait_cyc(32 * tbl[k].dv);
            expect_frame($sformatf("vec%0d", k), tbl[k].exp_data,
                         tbl[k].exp_pe, tbl[k].exp_fe, tbl[k].exp_brk);
            if (k == 0) begin
                check("vec0.latency_ok",
                      32'((rise_cyc - frame_start_cyc >= 610) && (rise_cyc - frame_start_cyc <= 630)),
                      32'd1);
            end
        end

        // False start: low for 16 cycles at div 4, then a good frame
        set_cfg(8, 1'b0, 1'b0, 1'b0, 4);
        snap();
        rx_i = 1'b0;
        wait_cyc(16);
        rx_i = 1'b1;
        wait_cyc(128);
        check("fstart.count", 32'(n_acc - s_acc), 32'd0);
        check("fstart.vhi",   32'(n_vhi - s_vhi), 32'd0);
        check("fstart.ferr",  32'(n_fe - s_fe), 32'd0);
        snap();
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        wait_cyc(128);
        expect_frame("fstart.next", 8'h55, 1'b0, 1'b0, 1'b0);

        // Overrun: back-to-back frames with no consumer
        data_ready_i = 1'b0;
        snap();
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        wait_cyc(64);
        check("ovr.pulse", 32'(n_ov - s_ov), 32'd1);
        check("ovr.data",  32'(data_o), 32'h11);
        check("ovr.valid", 32'(data_valid_o), 32'd1);
        check("ovr.ferr",  32'(n_fe - s_fe), 32'd0);
        data_ready_i = 1'b1;
        wait_cyc(1);
        data_ready_i = 1'b0;
        check("ovr.drop_valid", 32'(data_valid_o), 32'd0);
        check("ovr.acc_count",  32'(n_acc - s_acc), 32'd1);
        check("ovr.acc_data",   32'(acc_data), 32'h11);
        data_ready_i = 1'b1;
        wait_cyc(4);

        // Break: 5-bit, two stop bits, line low for 12 bit periods
        set_cfg(5, 1'b0, 1'b0, 1'b1, 4);
        snap();
        rx_i = 1'b0;
        wait_cyc(12 * 64);
        rx_i = 1'b1;
        wait_cyc(128);
        expect_frame("brk", 8'h00, 1'b0, 1'b1, 1'b1);

        // Reset mid-DATA with a held word, then a clean frame
        set_cfg(8, 1'b0, 1'b0, 1'b0, 4);
        data_ready_i = 1'b0;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        wait_cyc(64);
        check("mrst.held", 32'(data_valid_o), 32'd1);
        snap();
        rx_i = 1'b0;
        wait_cyc(64);
        rx_i = 1'b1;
        wait_cyc(3 * 64);
        arst_ni = 1'b0;
        #1;
        check("mrst.data",  32'(data_o), 32'd0);
        check("mrst.valid", 32'(data_valid_o), 32'd0);
        wait_cyc(3);
        arst_ni = 1'b1;
        data_ready_i = 1'b1;
        wait_cyc(256);
        check("mrst.count", 32'(n_acc - s_acc), 32'd0);
        check("mrst.ferr",  32'(n_fe - s_fe), 32'd0);
        check("mrst.perr",  32'(n_pe - s_pe), 32'd0);
        snap();
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        wait_cyc(128);
        expect_frame("mrst.next", 8'h81, 1'b0, 1'b0, 1'b0);

        // Randomized frames against the frame-rule model
        for (int r = 0; r < 20; r++) begin
            d     = 8'($urandom);
            cb    = $urandom_range(0, 15);
            pen   = 1'($urandom_range(0, 1));
            ptype = 1'($urandom_range(0, 1));
            xs    = 1'($urandom_range(0, 1));
            dv    = $urandom_range(1, 3);
            nb    = clampnb(cb);
            if ($urandom_range(0, 5) == 0) d = 8'h00;
            masked = d & 8'((1 << nb) - 1);
            pbit = 1'($countones(masked) % 2) ^ ptype;
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            s1 = ($urandom_range(0, 4) != 0);
            s2 = ($urandom_range(0, 4) != 0);

            epe  = pen && ((($countones(masked) + int'(pbit)) % 2) != int'(ptype));
            ebrk = (masked == 8'h00) && (!pen || !pbit) && !s1;
            efe  = !s1 || (xs && !s2) || ebrk;

            set_cfg(cb, pen, ptype, xs, dv);
            snap();
            send_frame(d, nb, pen, pbit, xs, s1, s2, dv);
            wait_cyc(32 * dv);
            expect_frame($sformatf("rnd%0d", r), masked, epe, efe, ebrk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
